stash_scanner: RTL and testbench
================================

Name: stash_scanner

Overview:
- Read-side controller for the Stash circular sample buffer. On a start request, it walks the Stash read pointer through all DEPTH entries by pulsing the Stash's next_sample input.
- It captures each displayed sample and emits it as a valid/ready stream with index and last flag. The stream feeds a downstream consumer such as a display multiplexer or serial dump.
- After a complete scan, the Stash read pointer is back where it started.

Parameters:
- DEPTH, 5, number of Stash entries to scan; must equal the Stash DEPTH and be >= 2.
- SETTLE, 1, cycles to wait after each next_sample pulse (and after start) before capturing stash_sample; must be >= 1.
- DATA_W, 8, sample width.
- Localparam IDX_W = $clog2(DEPTH).

Ports:
- clk  in  1  system clock; all logic is on the rising edge.
- reset  in  1  synchronous, active-high reset.
- start  in  1  single-cycle scan request; ignored while busy.
- stash_sample  in  DATA_W  Stash sample_out.
- stash_write  in  1  monitor of Stash sample_in_valid; a write moves the Stash read pointer.
- next_sample  out  1  one-cycle advance pulse to the Stash.
- out_data  out  DATA_W  captured sample.
- out_index  out  IDX_W  scan position, 0..DEPTH-1; 0 is the entry displayed at start.
- out_valid  out  1  out_data, out_index and out_last are valid.
- out_ready  in  1  consumer accepts the beat.
- out_last  out  1  high with the beat whose index is DEPTH-1.
- busy  out  1  scan in progress.
- aborted  out  1  last scan was aborted by a Stash write; sticky.

Behaviour:
- Reset: the block is synchronous and active-high. State goes to IDLE. next_sample, out_valid, out_last, busy and aborted are 0; out_data and out_index are 0. A reset mid-scan ends the scan immediately with no further next_sample pulses.
- States:
  - IDLE
  - SETTLE: counter cnt, counts down.
  - PRESENT: beat held on the stream interface.
  - ADVANCE: next_sample pulse cycle.
- IDLE: when start is sampled high at edge N:
  - state goes to SETTLE with idx=0 and cnt=SETTLE-1;
  - busy=1 and aborted=0 after edge N.
- SETTLE, at each edge:
  - if cnt==0: latch stash_sample into out_data; out_index=idx; out_last=(idx==DEPTH-1); out_valid=1; state goes to PRESENT;
  - else: cnt decrements.
  - With SETTLE=1, the first beat's out_valid rises after edge N+1.
- PRESENT:
  - out_data, out_index and out_last are held stable while out_valid=1 and out_ready=0.
  - A handshake at edge H (out_valid and out_ready) gives out_valid=0 and next_sample=1 after edge H; state goes to ADVANCE.
  - out_valid never drops without a handshake, except on abort or reset.
- ADVANCE: lasts exactly one cycle. At edge H+1:
  - next_sample=0;
  - if idx==DEPTH-1: state goes to IDLE and busy=0; out_last clears;
  - else: idx increments, cnt=SETTLE-1, state goes to SETTLE.
- Pulse count: a full scan issues exactly DEPTH next_sample pulses, including the final one. The Stash pointer wraps back to the starting entry.
- Throughput: with out_ready held high, each beat takes SETTLE+2 cycles.
- Abort: if stash_write is high at any edge while busy=1, in any state:
  - after that edge: state goes to IDLE; busy=0; out_valid=0; out_last=0; next_sample=0; aborted=1;
  - aborted holds until the next accepted start or reset.
  - A stash_write while IDLE has no effect.
- Simultaneous events:
  - start with stash_write in IDLE: the scan starts.
  - stash_write in the same cycle as a PRESENT handshake: abort wins, and no next_sample is issued.
- start while busy is ignored; the scan continues unchanged.
- All outputs are registered; there is no combinational path from inputs to outputs.

Test Plan:
- Setup: Stash (DEPTH=5) filled with 10,20,30,40,50,60, so it holds [60,20,30,40,50] with pointer on 60. Apply start with out_ready=1 and SETTLE=1.
  -> Beats 60/0, 20/1, 30/2, 40/3, 50/4, with out_last only on index 4.
  -> Exactly 5 next_sample pulses; busy falls 15 cycles after start; Stash sample_out is 60 again.
- Backpressure: out_ready=0 for 4 cycles on the beat with index 2.
  -> out_data=30 and out_index=2 are held stable and no next_sample is issued during the stall; after out_ready rises, the scan continues with 40.
- Abort: drive stash_write=1 for one cycle while the beat with index 1 is presented.
  -> Next cycle busy=0, out_valid=0, aborted=1.
  -> No further next_sample pulses; a new start clears aborted.
- start pulsed again during a scan.
  -> Ignored; the beat sequence and pulse count are identical to the first scenario.
- Reset asserted for 1 cycle mid-scan, in ADVANCE.
  -> Every output is 0 the next cycle; a start afterwards produces a clean 5-beat scan.
- Set SETTLE=3 and repeat the first scenario.
  -> Same data; beat spacing is 5 cycles; out_valid first rises 3 edges after the start edge.

Source files
------------

// File: rtl/stash_scanner.sv
// Read-side scanner for the Stash circular sample buffer.
// It steps the Stash read pointer once around the buffer and streams every sample with its index.
module stash_scanner #(
    parameter  int unsigned DEPTH  = 5,
    parameter  int unsigned SETTLE = 1,
    parameter  int unsigned DATA_W = 8,
    localparam int unsigned IDX_W  = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [DATA_W-1:0] stash_sample,
    input  logic              stash_write,
    output logic              next_sample,
    output logic [DATA_W-1:0] out_data,
    output logic [IDX_W-1:0]  out_index,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              out_last,
    output logic              busy,
    output logic              aborted
);

    localparam int unsigned CNT_W = (SETTLE > 1) ? $clog2(SETTLE) : 1;
    localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(SETTLE - 1);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(DEPTH - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_SETTLE,
        S_PRESENT,
        S_ADVANCE
    } state_t;

    state_t            state, state_nx;
    logic [IDX_W-1:0]  idx, idx_nx;
    logic [CNT_W-1:0]  cnt, cnt_nx;
    logic              next_sample_nx;
    logic [DATA_W-1:0] out_data_nx;
    logic [IDX_W-1:0]  out_index_nx;
    logic              out_valid_nx;
    logic              out_last_nx;
    logic              busy_nx;
    logic              aborted_nx;
    logic              abort_c;

    // A Stash write mid-scan moves its read pointer, so the walk is no longer meaningful.
    assign abort_c = busy && stash_write;

    // State and registered outputs
    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= S_IDLE;
            idx         <= '0;
            cnt         <= '0;
            next_sample <= 1'b0;
            out_data    <= '0;
            out_index   <= '0;
            out_valid   <= 1'b0;
            out_last    <= 1'b0;
            busy        <= 1'b0;
            aborted     <= 1'b0;
        end else begin
            state       <= state_nx;
            idx         <= idx_nx;
            cnt         <= cnt_nx;
            next_sample <= next_sample_nx;
            out_data    <= out_data_nx;
            out_index   <= out_index_nx;
            out_valid   <= out_valid_nx;
            out_last    <= out_last_nx;
            busy        <= busy_nx;
            aborted     <= aborted_nx;
        end
    end

    // Next-state logic
    always_comb begin
        state_nx = state;
        if (abort_c) begin
            state_nx = S_IDLE;
        end else begin
            case (state)
                S_IDLE:    if (start) state_nx = S_SETTLE;
                S_SETTLE:  if (cnt == '0) state_nx = S_PRESENT;
                S_PRESENT: if (out_valid && out_ready) state_nx = S_ADVANCE;
                S_ADVANCE: state_nx = (idx == IDX_LAST) ? S_IDLE : S_SETTLE;
                default:   state_nx = S_IDLE;
            endcase
        end
    end

    // Next values of the datapath and output registers
    always_comb begin
        idx_nx         = idx;
        cnt_nx         = cnt;
        next_sample_nx = 1'b0;
        out_data_nx    = out_data;
        out_index_nx   = out_index;
        out_valid_nx   = out_valid;
        out_last_nx    = out_last;
        busy_nx        = busy;
        aborted_nx     = aborted;
        case (state)
            S_IDLE: begin
                if (start) begin
                    idx_nx     = '0;
                    cnt_nx     = CNT_INIT;
                    busy_nx    = 1'b1;
                    aborted_nx = 1'b0;
                end
            end
            S_SETTLE: begin
                if (cnt == '0) begin
                    out_data_nx  = stash_sample;
                    out_index_nx = idx;
                    out_last_nx  = (idx == IDX_LAST);
                    out_valid_nx = 1'b1;
                end else begin
                    cnt_nx = cnt - CNT_W'(1);
                end
            end
            S_PRESENT: begin
                if (out_valid && out_ready) begin
                    out_valid_nx   = 1'b0;
                    next_sample_nx = 1'b1;
                end
            end
            S_ADVANCE: begin
                if (idx == IDX_LAST) begin
                    busy_nx     = 1'b0;
                    out_last_nx = 1'b0;
                end else begin
                    idx_nx = idx + IDX_W'(1);
                    cnt_nx = CNT_INIT;
                end
            end
            default: ;
        endcase
        // Abort overrides whatever the current state would have done, including a handshake.
        if (abort_c) begin
            busy_nx        = 1'b0;
            out_valid_nx   = 1'b0;
            out_last_nx    = 1'b0;
            next_sample_nx = 1'b0;
            aborted_nx     = 1'b1;
        end
    end

endmodule

// File: tb/tb_stash_scanner.sv
// Directed bench for stash_scanner: two instances (SETTLE=1 and SETTLE=3), each driving a
// behavioural DEPTH=5 Stash whose read pointer jumps to the newest write and steps on next_sample.
module tb_stash_scanner;

    localparam int unsigned DATA_W = 8;
    localparam int unsigned IDX_W  = 3;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic              reset;
    logic              stash_write;
    logic              stash_clr;
    logic [DATA_W-1:0] wdata;
    logic              out_ready;
    logic              start_a, start_b;

    logic              ns_a, valid_a, last_a, busy_a, ab_a;
    logic [DATA_W-1:0] data_a;
    logic [IDX_W-1:0]  idx_a;
    logic              ns_b, valid_b, last_b, busy_b, ab_b;
    logic [DATA_W-1:0] data_b;
    logic [IDX_W-1:0]  idx_b;

    logic [DATA_W-1:0] mem [2][5];
    int                rp [2] = '{0, 0};
    int                wp [2] = '{0, 0};
    int                pc [2] = '{0, 0};
    logic [DATA_W-1:0] sample_a, sample_b;

    int n_vec = 0;
    int n_err = 0;
    int sel   = 0;

    assign sample_a = mem[0][rp[0]];
    assign sample_b = mem[1][rp[1]];

    stash_scanner #(.DEPTH(5), .SETTLE(1), .DATA_W(DATA_W)) dut_a (
        .clk(clk), .reset(reset), .start(start_a), .stash_sample(sample_a),
        .stash_write(stash_write), .next_sample(ns_a), .out_data(data_a), .out_index(idx_a),
        .out_valid(valid_a), .out_ready(out_ready), .out_last(last_a), .busy(busy_a),
        .aborted(ab_a)
    );

    stash_scanner #(.DEPTH(5), .SETTLE(3), .DATA_W(DATA_W)) dut_b (
        .clk(clk), .reset(reset), .start(start_b), .stash_sample(sample_b),
        .stash_write(stash_write), .next_sample(ns_b), .out_data(data_b), .out_index(idx_b),
        .out_valid(valid_b), .out_ready(out_ready), .out_last(last_b), .busy(busy_b),
        .aborted(ab_b)
    );

    // Stash model: a write lands at the write pointer and the read pointer jumps to it.
    always @(posedge clk) begin
        for (int s = 0; s < 2; s++) begin
            if (stash_clr) begin
                rp[s] <= 0;
                wp[s] <= 0;
            end else if (stash_write) begin
                mem[s][wp[s]] <= wdata;
                rp[s]         <= wp[s];
                wp[s]         <= (wp[s] + 1) % 5;
            end else if ((s == 0) ? ns_a : ns_b) begin
                rp[s] <= (rp[s] + 1) % 5;
            end
        end
        if (ns_a) pc[0] <= pc[0] + 1;
        if (ns_b) pc[1] <= pc[1] + 1;
    end

    logic              c_valid, c_ns, c_last, c_busy, c_ab;
    logic [DATA_W-1:0] c_data, c_sample;
    logic [IDX_W-1:0]  c_idx;
    assign c_valid  = (sel != 0) ? valid_b  : valid_a;
    assign c_ns     = (sel != 0) ? ns_b     : ns_a;
    assign c_last   = (sel != 0) ? last_b   : last_a;
    assign c_busy   = (sel != 0) ? busy_b   : busy_a;
    assign c_ab     = (sel != 0) ? ab_b     : ab_a;
    assign c_data   = (sel != 0) ? data_b   : data_a;
    assign c_idx    = (sel != 0) ? idx_b    : idx_a;
    assign c_sample = (sel != 0) ? sample_b : sample_a;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic set_start(input logic v);
        if (sel != 0) start_b = v;
        else          start_a = v;
    endtask

    task automatic kick();
        set_start(1'b1);
        @(negedge clk);
        set_start(1'b0);
    endtask

    // Load 10..60 so the Stash holds [60,20,30,40,50] with the read pointer on 60.
    task automatic fill();
        stash_clr = 1'b1;
        @(negedge clk);
        stash_clr = 1'b0;
        for (int i = 0; i < 6; i++) begin
            stash_write = 1'b1;
            wdata       = 8'(10 * (i + 1));
            @(negedge clk);
        end
        stash_write = 1'b0;
    endtask

    task automatic check_all_zero(input string tag);
        chk({tag, "_busy"},  32'(c_busy),  0);
        chk({tag, "_valid"}, 32'(c_valid), 0);
        chk({tag, "_ns"},    32'(c_ns),    0);
        chk({tag, "_last"},  32'(c_last),  0);
        chk({tag, "_ab"},    32'(c_ab),    0);
        chk({tag, "_data"},  32'(c_data),  0);
        chk({tag, "_index"}, 32'(c_idx),   0);
    endtask

    // Full scan on the selected instance; optional stall on one beat and stray starts mid-scan.
    task automatic scan(input string tag, input int settle, input int stall_idx,
                        input int stall_len, input bit restart);
        logic [DATA_W-1:0] exp_d [5];
        int  base;
        int  k      = 0;
        int  beat   = 0;
        int  stall  = 0;
        int  rise   = 0;
        bit  was_v  = 1'b0;
        exp_d = '{8'd60, 8'd20, 8'd30, 8'd40, 8'd50};
        base  = pc[sel];
        out_ready = 1'b1;
        kick();
        chk({tag, "_busy_after_start"},  32'(c_busy),  1);
        chk({tag, "_aborted_cleared"},   32'(c_ab),    0);
        chk({tag, "_valid_after_start"}, 32'(c_valid), 0);
        while (beat < 5 && k < 200) begin
            @(negedge clk);
            k++;
            set_start(restart && (k == 5 || k == 9));
            if (c_valid && !was_v) begin
                if (beat == 0)
                    chk({tag, "_first_valid_edge"}, k, settle);
                else if (beat - 1 != stall_idx)
                    chk($sformatf("%s_spacing%0d", tag, beat), k - rise, settle + 2);
                rise = k;
            end
            was_v = c_valid;
            if (c_valid) begin
                if (beat == stall_idx && stall < stall_len) begin
                    out_ready = 1'b0;
                    stall++;
                    chk($sformatf("%s_stall%0d_data", tag, stall), 32'(c_data), 32'(exp_d[beat]));
                    chk($sformatf("%s_stall%0d_index", tag, stall), 32'(c_idx), beat);
                    chk($sformatf("%s_stall%0d_pulse", tag, stall), 32'(c_ns), 0);
                end else begin
                    out_ready = 1'b1;
                    chk($sformatf("%s_beat%0d_data", tag, beat), 32'(c_data), 32'(exp_d[beat]));
                    chk($sformatf("%s_beat%0d_index", tag, beat), 32'(c_idx), beat);
                    chk($sformatf("%s_beat%0d_last", tag, beat), 32'(c_last), (beat == 4) ? 1 : 0);
                    beat++;
                end
            end else begin
                out_ready = 1'b1;
            end
        end
        set_start(1'b0);
        chk({tag, "_beats_seen"}, beat, 5);
        while (c_busy && k < 400) begin
            @(negedge clk);
            k++;
        end
        chk({tag, "_busy_fall_edge"}, k, 5 * (settle + 2) + stall_len);
        chk({tag, "_pulse_count"}, pc[sel] - base, 5);
        chk({tag, "_stash_wrapped"}, 32'(c_sample), 60);
        chk({tag, "_valid_end"}, 32'(c_valid), 0);
        chk({tag, "_last_end"}, 32'(c_last), 0);
    endtask

    initial begin
        int  base;
        bit  found;
        reset       = 1'b1;
        stash_write = 1'b0;
        stash_clr   = 1'b0;
        wdata       = '0;
        out_ready   = 1'b1;
        start_a     = 1'b0;
        start_b     = 1'b0;
        @(negedge clk);
        @(negedge clk);
        fill();
        check_all_zero("reset");
        reset = 1'b0;
        @(negedge clk);

        scan("basic", 1, -1, 0, 1'b0);
        scan("backpressure", 1, 2, 4, 1'b0);
        scan("restart_ignored", 1, -1, 0, 1'b1);

        // Abort: Stash write on the same edge as the index-1 handshake.
        base  = pc[0];
        found = 1'b0;
        kick();
        for (int i = 0; i < 20 && !found; i++) begin
            if (c_valid && c_idx == 3'd1) found = 1'b1;
            else @(negedge clk);
        end
        chk("abort_reached_idx1", 32'(found), 1);
        stash_write = 1'b1;
        wdata       = 8'd99;
        @(negedge clk);
        stash_write = 1'b0;
        chk("abort_busy",    32'(c_busy),  0);
        chk("abort_valid",   32'(c_valid), 0);
        chk("abort_flag",    32'(c_ab),    1);
        chk("abort_no_ns",   32'(c_ns),    0);
        chk("abort_last",    32'(c_last),  0);
        chk("abort_pulses",  pc[0] - base, 1);
        repeat (5) @(negedge clk);
        chk("abort_pulses_later", pc[0] - base, 1);
        fill();
        chk("abort_sticky_idle_write", 32'(c_ab), 1);
        chk("abort_idle_write_busy",   32'(c_busy), 0);
        scan("after_abort", 1, -1, 0, 1'b0);

        // Reset while the first ADVANCE pulse is out.
        found = 1'b0;
        kick();
        for (int i = 0; i < 20 && !found; i++) begin
            if (c_ns) found = 1'b1;
            else @(negedge clk);
        end
        chk("reset_reached_advance", 32'(found), 1);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        check_all_zero("midscan_reset");
        fill();
        scan("after_reset", 1, -1, 0, 1'b0);

        sel = 1;
        scan("settle3", 3, -1, 0, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
